// File: rtl/ram_partitioned_mp.sv
// Multi-ported register-file RAM split into independently power-gated partitions,
// each with its own init engine restoring zero or sequential contents after reset/ungate.
module ram_partitioned_mp #(
   parameter int    DEPTH         = 128,
   parameter int    INDEX         = 7,
   parameter int    WIDTH         = 32,
   parameter int    NUM_RD_PORTS  = 4,
   parameter int    NUM_WR_PORTS  = 2,
   parameter int    NUM_PARTS     = 4,
   parameter int    NUM_PARTS_LOG = 2,
   parameter string RESET_VAL     = "ZERO",
   parameter int    SEQ_START     = 0,
   parameter int    READ_LATENCY  = 0,
   parameter int    BYPASS        = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_PARTS-1:0]                 partitionGated_i,
   input  logic [NUM_RD_PORTS-1:0][INDEX-1:0]   addr_i,
   output logic [NUM_RD_PORTS-1:0][WIDTH-1:0]   data_o,
   input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]   addrWr_i,
   input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]   dataWr_i,
   input  logic [NUM_WR_PORTS-1:0]              wrEn_i,
   output logic [NUM_PARTS-1:0]                 partReady_o,
   output logic                                 ramReady_o
);
   // state | meaning
   // GATED | partition powered off, contents lost, counter held at 0
   // INIT  | writing init value at local counter, one entry per cycle
   // READY | initialised; accepts writes and returns read data
   typedef enum logic [1:0] {GATED, INIT, READY} partState_t;

   localparam int LOCAL_BITS = INDEX - NUM_PARTS_LOG;
   localparam int PART_DEPTH = DEPTH / NUM_PARTS;
   localparam int CW = (PART_DEPTH > 1) ? $clog2(PART_DEPTH) : 1;
   localparam int PW = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;

   logic [WIDTH-1:0] mem [DEPTH];

   partState_t state     [NUM_PARTS];
   partState_t stateNext [NUM_PARTS];
   logic [CW-1:0] cnt     [NUM_PARTS];
   logic [CW-1:0] cntNext [NUM_PARTS];
   logic [NUM_PARTS-1:0] initWr;
   logic [NUM_PARTS-1:0] partReady;
   logic [NUM_WR_PORTS-1:0] wrCommit;
   logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rdVal;

   // With NUM_PARTS_LOG = 0 the shift clears every bit, so everything maps to partition 0.
   function automatic logic [PW-1:0] partOf(input logic [INDEX-1:0] a);
      return PW'(a >> LOCAL_BITS);
   endfunction

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PARTS; p++) begin
         if (reset) begin
            state[p] <= partitionGated_i[p] ? GATED : INIT;
            cnt[p]   <= '0;
         end else begin
            state[p] <= stateNext[p];
            cnt[p]   <= cntNext[p];
         end
      end
   end

   // An ungated GATED partition performs init cycle 0 on its first edge, so the
   // ungate latency matches the post-reset latency.
   always_comb begin
      for (int p = 0; p < NUM_PARTS; p++) begin
         stateNext[p] = state[p];
         cntNext[p]   = cnt[p];
         initWr[p]    = 1'b0;
         if (partitionGated_i[p]) begin
            stateNext[p] = GATED;
            cntNext[p]   = '0;
         end else begin
            case (state[p])
               GATED, INIT: begin
                  initWr[p] = 1'b1;
                  if (cnt[p] == CW'(PART_DEPTH - 1)) begin
                     stateNext[p] = READY;
                     cntNext[p]   = '0;
                  end else begin
                     stateNext[p] = INIT;
                     cntNext[p]   = cnt[p] + 1'b1;
                  end
               end
               READY:   stateNext[p] = READY;
               default: stateNext[p] = GATED;
            endcase
         end
         partReady[p] = !reset && (state[p] == READY) && !partitionGated_i[p];
      end
   end

   always_comb begin
      for (int w = 0; w < NUM_WR_PORTS; w++)
         wrCommit[w] = wrEn_i[w] && partReady[partOf(addrWr_i[w])];
   end

   // Later ports are applied after earlier ones, so the highest port wins on collision.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int p = 0; p < NUM_PARTS; p++) begin
            if (initWr[p])
               mem[INDEX'(p * PART_DEPTH + int'(cnt[p]))] <=
                  (RESET_VAL == "SEQ") ? WIDTH'(SEQ_START + p * PART_DEPTH + int'(cnt[p])) : '0;
         end
         for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wrCommit[w])
               mem[addrWr_i[w]] <= dataWr_i[w];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         rdVal[r] = partReady[partOf(addr_i[r])] ? mem[addr_i[r]] : '0;
         if (BYPASS != 0) begin
            for (int w = 0; w < NUM_WR_PORTS; w++) begin
               if (wrCommit[w] && (addrWr_i[w] == addr_i[r]))
                  rdVal[r] = dataWr_i[w];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_regRead
         always_ff @(posedge clk) begin
            if (reset) data_o <= '0;
            else       data_o <= rdVal;
         end
      end else begin : g_combRead
         assign data_o = rdVal;
      end
   endgenerate

   assign partReady_o = partReady;
   assign ramReady_o  = &(partReady | partitionGated_i);

endmodule

// File: tb/tb_ram_partitioned_mp.sv
// Directed bench: three instances (SEQ/no-bypass, ZERO/bypass, ZERO/registered read)
// driven by shared stimulus, checked against hand-computed values.
module tb_ram_partitioned_mp;
   logic clk = 1'b0;
   logic reset;
   logic [3:0] gate;
   logic [3:0][6:0] addrI;
   logic [1:0][6:0] addrWr;
   logic [1:0][31:0] dataWr;
   logic [1:0] wrEn;

   logic [3:0][31:0] dataA, dataB, dataC;
   logic [3:0] prA, prB, prC;
   logic rrA, rrB, rrC;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   ram_partitioned_mp #(.RESET_VAL("SEQ"), .SEQ_START(16), .READ_LATENCY(0), .BYPASS(0)) dutA (
      .clk(clk), .reset(reset), .partitionGated_i(gate), .addr_i(addrI), .data_o(dataA),
      .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn), .partReady_o(prA), .ramReady_o(rrA));

   ram_partitioned_mp #(.RESET_VAL("ZERO"), .READ_LATENCY(0), .BYPASS(1)) dutB (
      .clk(clk), .reset(reset), .partitionGated_i(gate), .addr_i(addrI), .data_o(dataB),
      .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn), .partReady_o(prB), .ramReady_o(rrB));

   ram_partitioned_mp #(.RESET_VAL("ZERO"), .READ_LATENCY(1), .BYPASS(0)) dutC (
      .clk(clk), .reset(reset), .partitionGated_i(gate), .addr_i(addrI), .data_o(dataC),
      .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn), .partReady_o(prC), .ramReady_o(rrC));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; gate = 4'hF; addrI = '0; addrWr = '0; dataWr = '0; wrEn = '0;
      tick(); tick();
      check("rst_allgated_ramReadyA", 32'(rrA), 32'd1);
      check("rst_allgated_ramReadyC", 32'(rrC), 32'd1);
      check("rst_partReadyA", 32'(prA), 32'd0);
      gate = 4'h0;
      #1;
      check("rst_ramReadyA", 32'(rrA), 32'd0);
      check("rst_ramReadyB", 32'(rrB), 32'd0);
      check("rst_regDataC", dataC[2], 32'd0);

      // drop reset, re-assert partway through init
      reset = 1'b0;
      repeat (10) tick();
      check("midinit_ramReadyA", 32'(rrA), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n = 0;
      while (!rrA && n < 40) begin tick(); n++; end
      check("init_latency", n, 32'd32);
      check("init_ramReadyB", 32'(rrB), 32'd1);
      check("init_partReadyC", 32'(prC), 32'hF);

      addrI[0] = 7'd77;
      #1;
      check("seq_read77", dataA[0], 32'd93);
      check("zero_read77", dataB[0], 32'd0);

      // two ports to the same address: port 1 wins
      addrWr[0] = 7'd9; dataWr[0] = 32'hA5;
      addrWr[1] = 7'd9; dataWr[1] = 32'h5A;
      wrEn = 2'b11; addrI[1] = 7'd9;
      #1;
      check("nobyp_old9", dataA[1], 32'd25);
      check("byp_collide9", dataB[1], 32'h5A);
      tick();
      wrEn = 2'b00;
      #1;
      check("collide9_A", dataA[1], 32'h5A);
      check("collide9_B", dataB[1], 32'h5A);
      check("reg_prewrite9", dataC[1], 32'd0);
      tick();
      check("reg_postwrite9", dataC[1], 32'h5A);

      addrWr[0] = 7'd40; dataWr[0] = 32'h1234; wrEn = 2'b01; addrI[0] = 7'd40;
      #1;
      check("nobyp_old40", dataA[0], 32'd56);
      check("byp_40", dataB[0], 32'h1234);
      tick();
      wrEn = 2'b00;
      #1;
      check("after40_A", dataA[0], 32'h1234);

      // registered read latency
      addrWr[0] = 7'd5; dataWr[0] = 32'h77; wrEn = 2'b01;
      tick();
      wrEn = 2'b00; addrI[2] = 7'd5;
      #1;
      check("lat1_before", dataC[2], 32'd0);
      tick();
      check("lat1_after", dataC[2], 32'h77);

      // gate partition 2, attempt a write, ungate
      gate = 4'b0100;
      tick();
      check("gated_partReady2", 32'(prA[2]), 32'd0);
      check("gated_ramReady", 32'(rrA), 32'd1);
      addrWr[0] = 7'd70; dataWr[0] = 32'hFF; wrEn = 2'b01; addrI[0] = 7'd70;
      #1;
      check("gated_byp_dropped", dataB[0], 32'd0);
      tick();
      wrEn = 2'b00; gate = 4'b0000;
      #1;
      check("reinit_ramReady", 32'(rrA), 32'd0);
      check("reinit_readA", dataA[0], 32'd0);
      n = 0;
      while (!prA[2] && n < 40) begin tick(); n++; end
      check("reinit_latency", n, 32'd32);
      check("reinit_seq70", dataA[0], 32'd86);
      check("reinit_zero70", dataB[0], 32'd0);
      check("reinit_ramReadyB", 32'(rrB), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
